// File: rtl/dice_roller.sv
// rtl/dice_roller.sv - dice face generator: free-running LFSR, spin phase, bounded rejection sampling
// Optional build macro DICE_ROLLER_ANIM_EN: result tumbles through legal faces during the spin phase.
module dice_roller #(
   parameter int          SPIN_CYCLES = 16,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   parameter int          MAX_TRIES   = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       roll,
   input  logic [2:0] dice,
   output logic [6:0] result,
   output logic       busy,
   output logic       done
);
   localparam int SW = $clog2(SPIN_CYCLES + 1);
   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam logic [SW-1:0] SPIN_LAST = SW'(SPIN_CYCLES - 1);
   localparam logic [TW-1:0] TRY_LAST  = TW'(MAX_TRIES - 1);

   typedef enum logic [1:0] {S_IDLE, S_SPIN, S_DRAW, S_FIN} state_t;

   state_t        state, next_state;
   logic [15:0]   lfsr;
   logic          roll_q;
   logic [2:0]    dice_l;
   logic [SW-1:0] spin_cnt;
   logic [TW-1:0] try_cnt;
   logic [6:0]    faces, mask, cand, res_val;
   logic          start, latch, try_inc, load_res;

   assign start = roll & ~roll_q;
   assign cand  = lfsr[6:0] & mask;

   always_comb begin
      faces = 7'd2;
      mask  = 7'd1;
      case (dice_l)
         3'd0: begin faces = 7'd2;   mask = 7'd1;   end
         3'd1: begin faces = 7'd4;   mask = 7'd3;   end
         3'd2: begin faces = 7'd6;   mask = 7'd7;   end
         3'd3: begin faces = 7'd8;   mask = 7'd7;   end
         3'd4: begin faces = 7'd10;  mask = 7'd15;  end
         3'd5: begin faces = 7'd12;  mask = 7'd15;  end
         3'd6: begin faces = 7'd20;  mask = 7'd31;  end
         default: begin faces = 7'd100; mask = 7'd127; end
      endcase
   end

`ifdef DICE_ROLLER_ANIM_EN
   logic [6:0] anim_val;
   always_comb begin
      anim_val = cand + 7'd1;
      if (anim_val > faces)
         anim_val = anim_val - faces;
   end
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      latch      = 1'b0;
      try_inc    = 1'b0;
      load_res   = 1'b0;
      res_val    = result;
      case (state)
         S_IDLE: begin
            if (start) begin
               latch      = 1'b1;
               next_state = S_SPIN;
            end
         end
         S_SPIN: begin
`ifdef DICE_ROLLER_ANIM_EN
            load_res = 1'b1;
            res_val  = anim_val;
`endif
            if (spin_cnt == SPIN_LAST)
               next_state = S_DRAW;
         end
         S_DRAW: begin
            // cand < 2*faces for every code, so the fallback fold is always in range
            if (cand < faces) begin
               load_res   = 1'b1;
               res_val    = cand + 7'd1;
               next_state = S_FIN;
            end else if (try_cnt == TRY_LAST) begin
               load_res   = 1'b1;
               res_val    = cand - faces + 7'd1;
               next_state = S_FIN;
            end else begin
               try_inc = 1'b1;
            end
         end
         S_FIN:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         lfsr     <= LFSR_SEED;
         roll_q   <= 1'b0;
         dice_l   <= 3'd0;
         spin_cnt <= '0;
         try_cnt  <= '0;
         result   <= 7'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         lfsr   <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
         roll_q <= roll;
         // status lags the state by one cycle so busy rises the cycle after start
         busy   <= (state == S_SPIN) || (state == S_DRAW);
         done   <= (state == S_FIN);
         if (latch) begin
            dice_l   <= dice;
            spin_cnt <= '0;
            try_cnt  <= '0;
         end else begin
            if (state == S_SPIN)
               spin_cnt <= spin_cnt + 1'b1;
            if (try_inc)
               try_cnt <= try_cnt + 1'b1;
         end
         if (load_res)
            result <= res_val;
      end
   end
endmodule

// File: tb/tb_dice_roller.sv
// tb/tb_dice_roller.sv - scoreboard bench for dice_roller; predicts each face from an LFSR model
// Honours DICE_ROLLER_ANIM_EN for the spin-phase result checks.
module tb_dice_roller;
   localparam int          SPIN  = 4;
   localparam int          TRIES = 8;
   localparam logic [15:0] SEED  = 16'hACE1;

   typedef struct {
      logic [6:0] res;
      int         lat;
   } exp_t;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       roll;
   logic [2:0] dice;
   logic [6:0] result;
   logic       busy, done;

   int          errors = 0;
   int          checks = 0;
   int          anim_changes = 0;
   logic [15:0] m;
   exp_t        sb[$];
   logic [127:0] seen;
   logic [6:0]  got, r1, r2;
   int          nseen;

   dice_roller #(.SPIN_CYCLES(SPIN), .LFSR_SEED(SEED), .MAX_TRIES(TRIES)) dut (
      .Clk(Clk), .Reset(Reset), .roll(roll), .dice(dice),
      .result(result), .busy(busy), .done(done)
   );

   always #5 Clk = ~Clk;

   function automatic logic [15:0] step(input logic [15:0] l);
      return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction

   always @(posedge Clk or posedge Reset)
      if (Reset) m <= SEED;
      else       m <= step(m);

   function automatic int faces_of(input int code);
      case (code)
         0: return 2;   1: return 4;   2: return 6;   3: return 8;
         4: return 10;  5: return 12;  6: return 20;  default: return 100;
      endcase
   endfunction

   function automatic int mask_of(input int code);
      case (code)
         0: return 1;   1: return 3;   2: return 7;   3: return 7;
         4: return 15;  5: return 15;  6: return 31;  default: return 127;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // l0 is the LFSR value just before the start edge; DRAW attempt j sees step^(SPIN+j)(l0)
   task automatic predict(input logic [15:0] l0, input int code, output logic [6:0] res, output int k);
      logic [15:0] l;
      logic [6:0]  cand, f, mk;
      l  = l0;
      f  = 7'(faces_of(code));
      mk = 7'(mask_of(code));
      res = 7'd0;
      k   = TRIES;
      for (int i = 0; i < SPIN; i++) l = step(l);
      for (int j = 1; j <= TRIES; j++) begin
         l = step(l);
         cand = l[6:0] & mk;
         if (cand < f) begin
            res = cand + 7'd1; k = j; return;
         end else if (j == TRIES) begin
            res = cand - f + 7'd1; k = j; return;
         end
      end
   endtask

   task automatic roll_once(input int code, input int hold, input bit spin_poke,
                            input int abort_at, output logic [6:0] res_out);
      logic [6:0] er, prev;
      int k, f, dones, limit;
      exp_t e;
      @(negedge Clk);
      dice = 3'(code);
      roll = 1'b1;
      prev = result;
      predict(m, code, er, k);
      e.res = er;
      e.lat = 1 + SPIN + k;
      sb.push_back(e);
      f       = faces_of(code);
      dones   = 0;
      res_out = 7'd0;
      limit   = (hold > 1 + SPIN + TRIES + 2) ? hold : 1 + SPIN + TRIES + 2;
      for (int c = 0; c <= limit; c++) begin
         @(negedge Clk);
         if (c == abort_at) begin
            #2 Reset = 1'b1;
            #1;
            check("abort_result", result, 0);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            @(negedge Clk);
            Reset = 1'b0;
            roll  = 1'b0;
            sb.delete();
            return;
         end
         if (c == 0) check("busy_lag", busy, 0);
         if (c == 1) check("busy_rise", busy, 1);
         if (c >= 1 && c <= SPIN) begin
`ifdef DICE_ROLLER_ANIM_EN
            check("spin_range", (result >= 1 && result <= f), 1);
            if (result !== prev) anim_changes++;
            prev = result;
`else
            check("spin_frozen", result, prev);
`endif
         end
         if (spin_poke) begin
            if (c == 1) begin dice = 3'd7; roll = 1'b0; end
            if (c == 2) roll = 1'b1;
            if (c == 3) roll = 1'b0;
         end
         if (hold > 0 && c == hold) roll = 1'b0;
         if (done === 1'b1) begin
            dones++;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("result", result, e.res);
               check("latency", c, e.lat);
            end
            check("range", (result >= 1 && result <= f), 1);
            check("busy_at_done", busy, 0);
            res_out = result;
            if (hold == 0 && !spin_poke) break;
         end
      end
      check("done_count", dones, 1);
      roll = 1'b0;
      sb.delete();
   endtask

   initial begin
      Reset = 1'b1;
      roll  = 1'b0;
      dice  = 3'd0;
      seen  = '0;
      #1;
      check("rst_result", result, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(negedge Clk);
      Reset = 1'b0;

      roll_once(2, 0, 1'b0, -1, got);
      roll_once(2, 0, 1'b0, 2, got);
      roll_once(5, 100, 1'b0, -1, got);
      roll_once(5, 0, 1'b0, -1, got);
      roll_once(2, 0, 1'b1, -1, got);

      roll_once(3, 0, 1'b0, SPIN, got);
      roll_once(4, 0, 1'b0, -1, r1);
      roll_once(3, 0, 1'b0, SPIN, got);
      roll_once(4, 0, 1'b0, -1, r2);
      check("repro_after_reset", r2, r1);

      for (int i = 0; i < 2000; i++) begin
         roll_once(0, 0, 1'b0, -1, got);
         seen[got] = 1'b1;
      end
      check("d2_both_faces", (seen[1] && seen[2]), 1);

      seen = '0;
      for (int i = 0; i < 5000; i++) begin
         roll_once(7, 0, 1'b0, -1, got);
         seen[got] = 1'b1;
      end
      nseen = 0;
      for (int v = 1; v <= 100; v++) if (seen[v]) nseen++;
      check("d100_all_faces", nseen, 100);
      check("d100_none_out", (seen[0] || (seen[127:101] != '0)), 0);

`ifdef DICE_ROLLER_ANIM_EN
      check("anim_moved", (anim_changes > 0), 1);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
